// File: rtl/mult_acc_collect.sv
// Collects LEN unsigned products into a group sum and queues each sum in a 2-entry output FIFO.
// Define MULT_ACC_COLLECT_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mult_acc_collect #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_rdy,
  input  logic [N+M-1:0]   result,
  input  logic             clear,
  input  logic             out_ready,
  output logic             acc_vld,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             drop_err,
  output logic             ovf
);

  localparam int P  = N + M;
  localparam int CW = $clog2(LEN);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] entry0;
  logic [ACC_W-1:0] entry1;
  logic [1:0]       fifo_cnt;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] sum;
  logic             take;
  logic             last;
  logic             pop;

  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - P){1'b0}}, result};
    carry   = sum_ext[ACC_W];
`ifdef MULT_ACC_COLLECT_SAT_EN
    // Once pinned at all-ones, any further nonzero addend carries again, so it holds.
    sum     = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    sum     = sum_ext[ACC_W-1:0];
`endif
    take    = result_rdy && !clear;
    last    = take && (count == CW'(LEN - 1));
    pop     = acc_vld && out_ready;
  end

  assign acc_vld = (fifo_cnt != 2'd0);
  assign acc_out = entry0;
  assign busy    = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      entry0   <= '0;
      entry1   <= '0;
      fifo_cnt <= 2'd0;
      drop_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (clear) begin
        state <= IDLE;
        acc   <= '0;
        count <= '0;
      end else if (result_rdy) begin
        if (carry) ovf <= 1'b1;
        if (last) begin
          state <= IDLE;
          acc   <= '0;
          count <= '0;
        end else begin
          state <= COLLECT;
          acc   <= sum;
          count <= count + CW'(1);
        end
      end

      // Pop shifts entry1 forward; a push into a full FIFO survives only if a pop frees a slot.
      case (fifo_cnt)
        2'd0: begin
          if (last) begin
            entry0   <= sum;
            fifo_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && last) begin
            entry0 <= sum;
          end else if (pop) begin
            fifo_cnt <= 2'd0;
          end else if (last) begin
            entry1   <= sum;
            fifo_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            entry0 <= entry1;
            if (last) entry1 <= sum;
            else fifo_cnt <= 2'd1;
          end else if (last) begin
            drop_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_collect.sv
// Self-checking bench for mult_acc_collect: directed scenarios plus randomized traffic against a queue model.
// A second instance with ACC_W=12 exercises accumulator overflow.
module tb_mult_acc_collect;
  localparam int N     = 8;
  localparam int M     = 4;
  localparam int P     = N + M;
  localparam int LEN   = 4;
  localparam int ACC_W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, result_rdy, clear, out_ready;
  logic [P-1:0]     result;
  logic             acc_vld, busy, drop_err, ovf;
  logic [ACC_W-1:0] acc_out;
  logic             acc_vld12, busy12, drop_err12, ovf12;
  logic [11:0]      acc_out12;

  mult_acc_collect #(.N(N), .M(M), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .result_rdy(result_rdy), .result(result), .clear(clear),
    .out_ready(out_ready), .acc_vld(acc_vld), .acc_out(acc_out), .busy(busy),
    .drop_err(drop_err), .ovf(ovf));

  mult_acc_collect #(.N(N), .M(M), .LEN(LEN), .ACC_W(12)) dut12 (
    .clk(clk), .rst(rst), .result_rdy(result_rdy), .result(result), .clear(clear),
    .out_ready(out_ready), .acc_vld(acc_vld12), .acc_out(acc_out12), .busy(busy12),
    .drop_err(drop_err12), .ovf(ovf12));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: running group sum, sample count, sticky flags, queue of completed sums.
  longint unsigned m_acc;
  int              m_cnt;
  bit              m_drop, m_ovf;
  longint unsigned q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("acc_vld", {31'd0, acc_vld}, {31'd0, q.size() != 0});
    if (q.size() != 0) check("acc_out", 32'(acc_out), 32'(q[0]));
    check("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
    check("drop_err", {31'd0, drop_err}, {31'd0, m_drop});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic do_reset(input bit rdy, input logic [P-1:0] res);
    rst = 1'b1; result_rdy = rdy; result = res; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; result_rdy = 1'b0;
    m_acc = 0; m_cnt = 0; m_drop = 0; m_ovf = 0; q.delete();
    check("rst_acc_out", 32'(acc_out), 32'd0);
    compare_all();
  endtask

  task automatic step(input bit rdy, input logic [P-1:0] res, input bit clr, input bit ordy);
    longint unsigned s;
    result_rdy = rdy; result = res; clear = clr; out_ready = ordy;
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (clr) begin
      m_acc = 0; m_cnt = 0;
    end else if (rdy) begin
      s = m_acc + longint'(res);
      if (s >= (64'd1 << ACC_W)) begin
        m_ovf = 1;
`ifdef MULT_ACC_COLLECT_SAT_EN
        s = (64'd1 << ACC_W) - 1;
`else
        s = s % (64'd1 << ACC_W);
`endif
      end
      m_cnt++;
      if (m_cnt == LEN) begin
        if (q.size() < 2) q.push_back(s);
        else m_drop = 1;
        m_acc = 0; m_cnt = 0;
      end else begin
        m_acc = s;
      end
    end
    @(posedge clk); #1;
    result_rdy = 1'b0; clear = 1'b0;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; result_rdy = 1'b0; result = '0; clear = 1'b0; out_ready = 1'b0;
    do_reset(0, 0);

    // Basic group: 3+5+7+9.
    step(1, 3, 0, 1); step(1, 5, 0, 1); step(1, 7, 0, 1); step(1, 9, 0, 1);
    check("s1_vld", {31'd0, acc_vld}, 32'd1);
    check("s1_out", 32'(acc_out), 32'd24);
    step(0, 0, 0, 1);

    // Back-to-back groups 1..8.
    for (int i = 1; i <= 8; i++) begin
      step(1, P'(i), 0, 1);
      if (i == 4) check("b2b_first", 32'(acc_out), 32'd10);
      if (i == 8) check("b2b_second", 32'(acc_out), 32'd26);
    end
    step(0, 0, 0, 1);

    // Three groups with the consumer stalled: third sum is dropped.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    check("full_drop", {31'd0, drop_err}, 32'd1);
    check("full_head", 32'(acc_out), 32'd4);
    step(0, 0, 0, 1);
    check("pop1_out", 32'(acc_out), 32'd4);
    step(0, 0, 0, 1);
    check("pop2_empty", {31'd0, acc_vld}, 32'd0);

    // Clear discards the partial group and the coincident sample.
    do_reset(0, 0);
    step(1, 10, 0, 1); step(1, 20, 0, 1); step(1, 30, 1, 1);
    check("clr_busy", {31'd0, busy}, 32'd0);
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1); step(1, 4, 0, 1);
    check("clr_out", 32'(acc_out), 32'd10);

    // Overflow on the 12-bit instance.
    do_reset(0, 0);
    step(1, 4095, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    check("ovf12", {31'd0, ovf12}, 32'd1);
    check("ovf12_vld", {31'd0, acc_vld12}, 32'd1);
`ifdef MULT_ACC_COLLECT_SAT_EN
    check("ovf12_out", 32'(acc_out12), 32'd4095);
`else
    check("ovf12_out", 32'(acc_out12), 32'd0);
`endif
    check("ovf12_busy", {31'd0, busy12}, 32'd0);
    check("ovf12_drop", {31'd0, drop_err12}, 32'd0);

    // Reset during the third sample with an entry pending.
    do_reset(0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    do_reset(1, 1);
    check("rst_mid_vld", {31'd0, acc_vld}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 1);
    check("rst_fresh", 32'(acc_out), 32'd8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(0, 0);
      else step($urandom_range(0, 9) < 7, P'($urandom), $urandom_range(0, 19) == 0,
                $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
